calc_port_responder: RTL and testbench

- Responder end of the single-port calculator command interface.
- Accepts a command plus two 32-bit operands over two consecutive cycles, computes the result, and returns a response code and data after a fixed latency.
- Sits behind the calculator port that the existing addition benches drive.
- Used as a stand-alone DUT and as the reference responder for the port's initiator-side benches.

---
 rtl/calc_pkg.sv | 47 ++++
 rtl/calc_alu.sv | 65 ++++++
 rtl/calc_port_responder.sv | 123 ++++++++++++
 tb/tb_calc_port_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the single-port calculator responder.
//   cmd_t    : command codes accepted on cmd_in (other codes are invalid)
//   resp_t   : response codes driven on out_resp (code 3 is never driven)
//   state_t  : responder FSM states
//   resp_code: maps an ALU error flag onto the response code to return
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_DATA_W = 32;
  localparam int CALC_CMD_W  = 4;
  localparam int CALC_CNT_W  = 4;

  typedef enum logic [CALC_CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_t;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  // Response code for a completed operation.
  function automatic resp_t resp_code(input logic err);
    resp_t code;
    if (err) begin
      code = RESP_ERR;
    end else begin
      code = RESP_OK;
    end
    return code;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// ---------------------------------------------------------------------------
// calc_alu
// Purely combinational unsigned arithmetic for the calculator responder.
//   cmd    in  4       command code (raw, may be an invalid code)
//   op1    in  DATA_W  first operand
//   op2    in  DATA_W  second operand / shift amount (low bits only)
//   result out DATA_W  result, forced to zero whenever err is set
//   err    out 1       overflow, underflow or invalid command
// ---------------------------------------------------------------------------
module calc_alu import calc_pkg::*; #(
  parameter int DATA_W = CALC_DATA_W
) (
  input  logic [CALC_CMD_W-1:0] cmd,
  input  logic [DATA_W-1:0]     op1,
  input  logic [DATA_W-1:0]     op2,
  output logic [DATA_W-1:0]     result,
  output logic                  err
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   sum_s;
  logic [SH_W-1:0]   shamt_s;

  // Extra top bit of the sum is the carry that flags an add overflow.
  assign sum_s   = {1'b0, op1} + {1'b0, op2};
  // Only the low bits of op2 select the shift distance; the rest are ignored.
  assign shamt_s = op2[SH_W-1:0];

  // Operation select; every error path returns a zero result.
  always_comb begin
    result = {DATA_W{1'b0}};
    err    = 1'b0;
    case (cmd)
      CMD_NOP: begin
        result = {DATA_W{1'b0}};
        err    = 1'b0;
      end
      CMD_ADD: begin
        if (sum_s[DATA_W]) begin
          err = 1'b1;
        end else begin
          result = sum_s[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 > op1) begin
          err = 1'b1;
        end else begin
          result = op1 - op2;
        end
      end
      CMD_SHL: begin
        result = op1 << shamt_s;
      end
      CMD_SHR: begin
        result = op1 >> shamt_s;
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/calc_port_responder.sv
// ---------------------------------------------------------------------------
// calc_port_responder
// Responder end of the single-port calculator interface. A command with
// operand 1 is taken in one cycle, operand 2 in the next; the result is
// computed and registered on the operand-2 edge and returned LATENCY cycles
// later as a one-cycle response.
//   c_clk    in  1       port clock, rising edge
//   reset_n  in  1       asynchronous active-low reset
//   cmd_in   in  4       command code, sampled only while idle
//   data_in  in  DATA_W  operand 1 (command cycle) / operand 2 (next cycle)
//   out_resp out 2       response code, non-zero for exactly one cycle
//   data_out out DATA_W  result, non-zero only alongside a success response
//   busy     out 1       high from operand-2 capture through the response
// ---------------------------------------------------------------------------
module calc_port_responder import calc_pkg::*; #(
  parameter int LATENCY = 3,
  parameter int DATA_W  = CALC_DATA_W
) (
  input  logic                  c_clk,
  input  logic                  reset_n,
  input  logic [CALC_CMD_W-1:0] cmd_in,
  input  logic [DATA_W-1:0]     data_in,
  output logic [1:0]            out_resp,
  output logic [DATA_W-1:0]     data_out,
  output logic                  busy
);

  localparam logic [CALC_CNT_W-1:0] CNT_LOAD = CALC_CNT_W'(LATENCY - 1);

  state_t                  state_r;
  logic [CALC_CMD_W-1:0]   cmd_r;
  logic [DATA_W-1:0]       op1_r;
  logic [CALC_CNT_W-1:0]   cnt_r;
  logic [DATA_W-1:0]       res_r;
  logic                    err_r;

  logic [DATA_W-1:0]       alu_res_s;
  logic                    alu_err_s;

  // Operand 2 is fed straight from the port so the result can be registered
  // on the same edge that would capture operand 2.
  calc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .cmd    (cmd_r),
    .op1    (op1_r),
    .op2    (data_in),
    .result (alu_res_s),
    .err    (alu_err_s)
  );

  // Transaction FSM, latency counter and registered port outputs.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      cmd_r    <= {CALC_CMD_W{1'b0}};
      op1_r    <= {DATA_W{1'b0}};
      cnt_r    <= {CALC_CNT_W{1'b0}};
      res_r    <= {DATA_W{1'b0}};
      err_r    <= 1'b0;
      out_resp <= RESP_NONE;
      data_out <= {DATA_W{1'b0}};
      busy     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_resp <= RESP_NONE;
          data_out <= {DATA_W{1'b0}};
          busy     <= 1'b0;
          if (cmd_in != 4'd0) begin
            cmd_r   <= cmd_in;
            op1_r   <= data_in;
            state_r <= OP2;
          end else begin
            state_r <= IDLE;
          end
        end
        OP2: begin
          // cmd_in is deliberately ignored here: this cycle belongs to op2.
          res_r    <= alu_res_s;
          err_r    <= alu_err_s;
          cnt_r    <= CNT_LOAD;
          busy     <= 1'b1;
          out_resp <= RESP_NONE;
          data_out <= {DATA_W{1'b0}};
          if (LATENCY == 1) begin
            state_r <= RESP;
          end else begin
            state_r <= EXEC;
          end
        end
        EXEC: begin
          busy     <= 1'b1;
          out_resp <= RESP_NONE;
          data_out <= {DATA_W{1'b0}};
          // Leaving on the count of one lands the response edge exactly
          // LATENCY edges after the operand-2 edge.
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= RESP;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            state_r <= EXEC;
          end
        end
        RESP: begin
          out_resp <= resp_code(err_r);
          data_out <= res_r;
          busy     <= 1'b1;
          cnt_r    <= 4'd0;
          state_r  <= IDLE;
        end
        default: begin
          out_resp <= RESP_NONE;
          data_out <= {DATA_W{1'b0}};
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// ---------------------------------------------------------------------------
// tb_calc_port_responder
// Directed bench for calc_port_responder at LATENCY 3, 1 and 15. Each
// transaction is checked cycle by cycle against hand-computed values.
// ---------------------------------------------------------------------------
module tb_calc_port_responder;

  logic        c_clk;
  logic        reset_n;
  logic [3:0]  cmd_a  [3];
  logic [31:0] data_a [3];
  logic [1:0]  resp_a [3];
  logic [31:0] dout_a [3];
  logic        busy_a [3];

  int checks;
  int errors;

  calc_port_responder #(.LATENCY(3)) u_dut_l3 (
    .c_clk(c_clk), .reset_n(reset_n), .cmd_in(cmd_a[0]), .data_in(data_a[0]),
    .out_resp(resp_a[0]), .data_out(dout_a[0]), .busy(busy_a[0])
  );

  calc_port_responder #(.LATENCY(1)) u_dut_l1 (
    .c_clk(c_clk), .reset_n(reset_n), .cmd_in(cmd_a[1]), .data_in(data_a[1]),
    .out_resp(resp_a[1]), .data_out(dout_a[1]), .busy(busy_a[1])
  );

  calc_port_responder #(.LATENCY(15)) u_dut_l15 (
    .c_clk(c_clk), .reset_n(reset_n), .cmd_in(cmd_a[2]), .data_in(data_a[2]),
    .out_resp(resp_a[2]), .data_out(dout_a[2]), .busy(busy_a[2])
  );

  // Free-running port clock.
  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // Hard stop if the run overruns its cycle budget.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction on instance d; optionally pushes a command in EXEC.
  task automatic run_op(input int d, input int lat, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed,
                        input string tag, input bit intrude);
    @(posedge c_clk); #1;
    cmd_a[d]  = cmd;
    data_a[d] = a;
    @(posedge c_clk); #1;
    cmd_a[d]  = 4'd0;
    data_a[d] = b;
    for (int k = 0; k <= lat + 1; k++) begin
      @(posedge c_clk); #1;
      if (intrude && k == 0) begin
        cmd_a[d]  = 4'd1;
        data_a[d] = 32'h0000_0055;
      end else begin
        cmd_a[d]  = 4'd0;
        data_a[d] = 32'h0000_0000;
      end
      if (k < lat) begin
        check($sformatf("%s_resp_pre%0d", tag, k), 64'(resp_a[d]), 64'd0);
        check($sformatf("%s_busy%0d", tag, k), 64'(busy_a[d]), 64'd1);
      end else if (k == lat) begin
        check($sformatf("%s_resp", tag), 64'(resp_a[d]), 64'(er));
        check($sformatf("%s_data", tag), 64'(dout_a[d]), 64'(ed));
        check($sformatf("%s_busy_resp", tag), 64'(busy_a[d]), 64'd1);
      end else begin
        check($sformatf("%s_resp_post", tag), 64'(resp_a[d]), 64'd0);
        check($sformatf("%s_data_post", tag), 64'(dout_a[d]), 64'd0);
        check($sformatf("%s_busy_post", tag), 64'(busy_a[d]), 64'd0);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_a[i]  = 4'd0;
      data_a[i] = 32'h0000_0000;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_resp%0d", i), 64'(resp_a[i]), 64'd0);
      check($sformatf("rst_data%0d", i), 64'(dout_a[i]), 64'd0);
      check($sformatf("rst_busy%0d", i), 64'(busy_a[i]), 64'd0);
    end
    @(negedge c_clk);
    reset_n = 1'b1;

    // Walking one through the adder.
    for (int k = 0; k <= 30; k++) begin
      run_op(0, 3, 4'd1, 32'h1 << k, 32'h0, 2'd1, 32'h1 << k,
             $sformatf("walk%0d", k), 1'b0);
    end

    run_op(0, 3, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, "add_ovf", 1'b0);
    run_op(0, 3, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, "add_max", 1'b0);
    run_op(0, 3, 4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000, "sub_eq", 1'b0);
    run_op(0, 3, 4'd2, 32'h0000_0003, 32'h0000_0004, 2'd2, 32'h0000_0000, "sub_unf", 1'b0);
    run_op(0, 3, 4'd2, 32'h0000_0010, 32'h0000_0001, 2'd1, 32'h0000_000F, "sub_ok", 1'b0);
    run_op(0, 3, 4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000, "shl31", 1'b0);
    run_op(0, 3, 4'd5, 32'h0000_0001, 32'h0000_0025, 2'd1, 32'h0000_0020, "shl_mask", 1'b0);
    run_op(0, 3, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, "shr31", 1'b0);
    run_op(0, 3, 4'd5, 32'h0000_ABCD, 32'h0000_0000, 2'd1, 32'h0000_ABCD, "shl0", 1'b0);
    run_op(0, 3, 4'd3, 32'h0000_0001, 32'h0000_0002, 2'd2, 32'h0000_0000, "inv3", 1'b0);
    run_op(0, 3, 4'd15, 32'h0000_0001, 32'h0000_0002, 2'd2, 32'h0000_0000, "inv15", 1'b0);

    // A command pushed during EXEC must not produce a second response.
    run_op(0, 3, 4'd1, 32'h0000_0100, 32'h0000_0023, 2'd1, 32'h0000_0123, "ovl", 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge c_clk); #1;
      check($sformatf("ovl_idle_resp%0d", i), 64'(resp_a[0]), 64'd0);
      check($sformatf("ovl_idle_busy%0d", i), 64'(busy_a[0]), 64'd0);
    end

    // Other latencies.
    run_op(1, 1, 4'd1, 32'h0000_0002, 32'h0000_0003, 2'd1, 32'h0000_0005, "l1_add", 1'b0);
    run_op(1, 1, 4'd2, 32'h0000_0001, 32'h0000_0002, 2'd2, 32'h0000_0000, "l1_sub", 1'b0);
    run_op(2, 15, 4'd6, 32'hF000_0000, 32'h0000_0004, 2'd1, 32'h0F00_0000, "l15_shr", 1'b0);
    run_op(2, 15, 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 2'd2, 32'h0000_0000, "l15_ovf", 1'b0);

    // Reset in the middle of EXEC: busy drops at once, no response later.
    @(posedge c_clk); #1;
    cmd_a[0] = 4'd1; data_a[0] = 32'h0000_0007;
    @(posedge c_clk); #1;
    cmd_a[0] = 4'd0; data_a[0] = 32'h0000_0008;
    @(posedge c_clk); #1;
    data_a[0] = 32'h0000_0000;
    check("rstx_busy_before", 64'(busy_a[0]), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstx_busy_async", 64'(busy_a[0]), 64'd0);
    check("rstx_resp_async", 64'(resp_a[0]), 64'd0);
    @(negedge c_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge c_clk); #1;
      check($sformatf("rstx_noresp%0d", i), 64'(resp_a[0]), 64'd0);
      check($sformatf("rstx_nobusy%0d", i), 64'(busy_a[0]), 64'd0);
    end

    // Reset during the response cycle clears out_resp/data_out immediately.
    @(posedge c_clk); #1;
    cmd_a[0] = 4'd2; data_a[0] = 32'h0000_0014;
    @(posedge c_clk); #1;
    cmd_a[0] = 4'd0; data_a[0] = 32'h0000_0006;
    repeat (4) @(posedge c_clk);
    #1;
    data_a[0] = 32'h0000_0000;
    check("rstr_resp_before", 64'(resp_a[0]), 64'd1);
    check("rstr_data_before", 64'(dout_a[0]), 64'h0000_000E);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstr_resp_async", 64'(resp_a[0]), 64'd0);
    check("rstr_data_async", 64'(dout_a[0]), 64'd0);
    check("rstr_busy_async", 64'(busy_a[0]), 64'd0);
    @(negedge c_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge c_clk); #1;
      check($sformatf("rstr_noresp%0d", i), 64'(resp_a[0]), 64'd0);
    end

    // Normal service resumes after reset.
    run_op(0, 3, 4'd1, 32'h0000_0001, 32'h0000_0002, 2'd1, 32'h0000_0003, "post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
